vote_display_ctrl: RTL and testbench
====================================

// Module: vote_display_ctrl
// PURPOSE
//   Parametrised display/mode controller for the voting machine. Sits between the
//   vote counters and the LED bank: in voting mode it flashes an acknowledge pulse
//   on each valid vote; in result mode it shows a button-selected candidate's count,
//   or auto-scrolls through all candidates when none is selected. Also reports the
//   current leader and a tie flag.
// PARAMETERS
//   NUM_CAND      4   number of candidates (>=2)
//   CNT_W         8   vote-count width = LED bank width
//   PULSE_CYCLES  5   voting-mode acknowledge flash length, clk cycles (>=1)
//   SCROLL_CYCLES 8   result-mode auto-scroll dwell per candidate, clk cycles (>=1)
//   (derived) IDX_W = max(1, $clog2(NUM_CAND))
// PORTS
//   clk               in   1                 system clock, rising edge
//   rst               in   1                 asynchronous, active-high reset
//   mode              in   1                 0 = voting, 1 = result
//   valid_vote_casted in   1                 1-cycle pulse from vote logger
//   cand_votes        in   NUM_CAND*CNT_W    packed counts; cand i at [i*CNT_W +: CNT_W]
//   cand_buttons      in   NUM_CAND          candidate buttons, synchronised, level
//   leds              out  CNT_W             LED bank
//   sel_idx           out  IDX_W             candidate currently shown (result mode)
//   scanning          out  1                 1 while in auto-scroll
//   winner_idx        out  IDX_W             lowest index holding the maximum count
//   tie               out  1                 1 if >=2 candidates share the maximum
// BEHAVIOUR
//   - Reset (async assert, sync release): all outputs 0, state VOTE_IDLE, counters 0.
//   - All outputs registered: respond one clk after the causing input.
//   - States: VOTE_IDLE, VOTE_ACK, RES_SCAN, RES_HOLD.
//   - VOTE_IDLE: leds=0. valid_vote_casted -> VOTE_ACK, leds=all-ones next cycle.
//   - VOTE_ACK: leds all-ones for exactly PULSE_CYCLES cycles, then VOTE_IDLE, leds=0.
//     valid_vote_casted during ACK restarts the full PULSE_CYCLES window.
//   - mode 0->1 from any voting state (ACK aborted): -> RES_SCAN, sel_idx=0,
//     scanning=1, dwell counter cleared. valid_vote_casted ignored while mode=1.
//   - RES_SCAN: leds=cand_votes[sel_idx]; sel_idx increments every SCROLL_CYCLES,
//     wraps NUM_CAND-1 -> 0. Any button -> RES_HOLD.
//   - Button priority: lowest asserted index wins when several pressed together.
//   - RES_HOLD: sel_idx = latched button index, scanning=0; held after release;
//     new button press re-latches. leds track cand_votes[sel_idx] every cycle
//     (live count, not a snapshot).
//   - mode 1->0 from any result state: -> VOTE_IDLE, leds=0, sel_idx=0, scanning=0;
//     a valid_vote_casted in that same cycle -> VOTE_ACK directly.
//   - winner_idx/tie: recomputed every cycle in every state from cand_votes,
//     unsigned compare, one-cycle latency. All counts 0 -> winner_idx=0, tie=1.
//   - No arithmetic on counts; counter widths sized so PULSE/SCROLL never overflow.
// TESTING
//   1 rst high mid-ACK -> leds, sel_idx, scanning, winner_idx, tie = 0 asynchronously.
//   2 mode=0, vote pulse at cycle 10 -> leds=8'hFF cycles 11..15, 8'h00 at 16;
//     second pulse at 13 -> leds 8'hFF through cycle 18.
//   3 mode=1, no buttons, votes {3,7,2,9} -> leds 3,7,2,9,3 each for 8 cycles;
//     scanning=1 throughout.
//   4 buttons 4'b0110 pressed then released -> sel_idx=1, leds=7, held;
//     cand1 count changes to 8 -> leds=8 next cycle.
//   5 votes {5,9,9,1} -> winner_idx=1, tie=1; change to {5,9,10,1} -> winner_idx=2, tie=0.
//   6 mode 1->0 while holding -> leds=0 next cycle; mode 0->1 mid-ACK -> RES_SCAN, sel_idx=0.

Source files
------------

// File: rtl/vote_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vote_display_ctrl
// Description : Display/mode controller between the vote counters and the LED
//               bank. Voting mode flashes an acknowledge pulse on every valid
//               vote; result mode shows a button-selected candidate's live
//               count, or auto-scrolls through all candidates when nothing is
//               selected. Also reports the current leader and a tie flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_display_ctrl #(
    parameter int NUM_CAND      = 4,
    parameter int CNT_W         = 8,
    parameter int PULSE_CYCLES  = 5,
    parameter int SCROLL_CYCLES = 8,
    localparam int IDX_W        = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      valid_vote_casted,
    input  logic [NUM_CAND*CNT_W-1:0] cand_votes,
    input  logic [NUM_CAND-1:0]       cand_buttons,
    output logic [CNT_W-1:0]          leds,
    output logic [IDX_W-1:0]          sel_idx,
    output logic                      scanning,
    output logic [IDX_W-1:0]          winner_idx,
    output logic                      tie
);

    // Counter widths hold the largest terminal value without wrapping.
    localparam int                   c_PULSE_W     = $clog2(PULSE_CYCLES + 1);
    localparam int                   c_SCROLL_W    = $clog2(SCROLL_CYCLES + 1);
    localparam logic [c_PULSE_W-1:0]  c_PULSE_LAST  = c_PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [c_SCROLL_W-1:0] c_SCROLL_LAST = c_SCROLL_W'(SCROLL_CYCLES - 1);
    localparam logic [IDX_W-1:0]      c_LAST_IDX    = IDX_W'(NUM_CAND - 1);
    localparam logic [CNT_W-1:0]      c_ALL_ONES    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        VOTE_IDLE = 2'd0,
        VOTE_ACK  = 2'd1,
        RES_SCAN  = 2'd2,
        RES_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_PULSE_W-1:0]   r_pulse_cnt;
    logic [c_SCROLL_W-1:0]  r_dwell_cnt;
    logic [CNT_W-1:0]       r_leds;
    logic [IDX_W-1:0]       r_sel_idx;
    logic                   r_scanning;
    logic [IDX_W-1:0]       r_winner_idx;
    logic                   r_tie;

    logic [CNT_W-1:0]       w_votes [NUM_CAND];
    logic                   w_btn_any;
    logic [IDX_W-1:0]       w_btn_idx;
    logic [IDX_W-1:0]       w_scan_next;
    logic [CNT_W-1:0]       w_max;
    logic [IDX_W-1:0]       w_win;
    logic                   w_tie;

    // Split the packed count bus into one entry per candidate.
    generate
        for (genvar g = 0; g < NUM_CAND; g++) begin : g_unpack
            assign w_votes[g] = cand_votes[g*CNT_W +: CNT_W];
        end
    endgenerate

    // Lowest-numbered pressed button wins when several are held together.
    always_comb begin
        w_btn_any = |cand_buttons;
        w_btn_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_buttons[i]) begin
                w_btn_idx = IDX_W'(i);
            end
        end
    end

    // Next candidate in the auto-scroll rotation, wrapping after the last one.
    always_comb begin
        w_scan_next = (r_sel_idx == c_LAST_IDX) ? '0 : r_sel_idx + IDX_W'(1);
    end

    // Leader search: strict greater-than keeps the lowest index on equal
    // maxima; any later equal count flags a tie, a new larger count clears it.
    always_comb begin
        w_max = w_votes[0];
        w_win = '0;
        w_tie = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (w_votes[i] > w_max) begin
                w_max = w_votes[i];
                w_win = IDX_W'(i);
                w_tie = 1'b0;
            end else if (w_votes[i] == w_max) begin
                w_tie = 1'b1;
            end
        end
    end

    // Register leader/tie every cycle regardless of mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winner_idx <= '0;
            r_tie        <= 1'b0;
        end else begin
            r_winner_idx <= w_win;
            r_tie        <= w_tie;
        end
    end

    // Mode/display state machine with registered LED, index and scan outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= VOTE_IDLE;
            r_pulse_cnt <= '0;
            r_dwell_cnt <= '0;
            r_leds      <= '0;
            r_sel_idx   <= '0;
            r_scanning  <= 1'b0;
        end else begin
            case (r_state)
                VOTE_IDLE: begin
                    if (mode) begin
                        r_state     <= RES_SCAN;
                        r_sel_idx   <= '0;
                        r_scanning  <= 1'b1;
                        r_dwell_cnt <= '0;
                        r_pulse_cnt <= '0;
                        r_leds      <= w_votes[0];
                    end else if (valid_vote_casted) begin
                        r_state     <= VOTE_ACK;
                        r_pulse_cnt <= c_PULSE_LAST;
                        r_leds      <= c_ALL_ONES;
                    end else begin
                        r_leds      <= '0;
                    end
                end

                VOTE_ACK: begin
                    if (mode) begin
                        // Result mode aborts any flash in progress.
                        r_state     <= RES_SCAN;
                        r_sel_idx   <= '0;
                        r_scanning  <= 1'b1;
                        r_dwell_cnt <= '0;
                        r_pulse_cnt <= '0;
                        r_leds      <= w_votes[0];
                    end else if (valid_vote_casted) begin
                        // A fresh vote restarts the whole flash window.
                        r_pulse_cnt <= c_PULSE_LAST;
                        r_leds      <= c_ALL_ONES;
                    end else if (r_pulse_cnt == '0) begin
                        r_state     <= VOTE_IDLE;
                        r_leds      <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - c_PULSE_W'(1);
                        r_leds      <= c_ALL_ONES;
                    end
                end

                RES_SCAN: begin
                    if (!mode) begin
                        r_sel_idx   <= '0;
                        r_scanning  <= 1'b0;
                        r_dwell_cnt <= '0;
                        if (valid_vote_casted) begin
                            r_state     <= VOTE_ACK;
                            r_pulse_cnt <= c_PULSE_LAST;
                            r_leds      <= c_ALL_ONES;
                        end else begin
                            r_state     <= VOTE_IDLE;
                            r_leds      <= '0;
                        end
                    end else if (w_btn_any) begin
                        r_state     <= RES_HOLD;
                        r_sel_idx   <= w_btn_idx;
                        r_scanning  <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_leds      <= w_votes[w_btn_idx];
                    end else if (r_dwell_cnt == c_SCROLL_LAST) begin
                        r_dwell_cnt <= '0;
                        r_sel_idx   <= w_scan_next;
                        r_leds      <= w_votes[w_scan_next];
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + c_SCROLL_W'(1);
                        r_leds      <= w_votes[r_sel_idx];
                    end
                end

                RES_HOLD: begin
                    if (!mode) begin
                        r_sel_idx   <= '0;
                        r_scanning  <= 1'b0;
                        r_dwell_cnt <= '0;
                        if (valid_vote_casted) begin
                            r_state     <= VOTE_ACK;
                            r_pulse_cnt <= c_PULSE_LAST;
                            r_leds      <= c_ALL_ONES;
                        end else begin
                            r_state     <= VOTE_IDLE;
                            r_leds      <= '0;
                        end
                    end else if (w_btn_any) begin
                        r_sel_idx   <= w_btn_idx;
                        r_leds      <= w_votes[w_btn_idx];
                    end else begin
                        // Live count of the latched candidate, not a snapshot.
                        r_leds      <= w_votes[r_sel_idx];
                    end
                end

                default: begin
                    r_state     <= VOTE_IDLE;
                    r_pulse_cnt <= '0;
                    r_dwell_cnt <= '0;
                    r_leds      <= '0;
                    r_sel_idx   <= '0;
                    r_scanning  <= 1'b0;
                end
            endcase
        end
    end

    assign leds       = r_leds;
    assign sel_idx    = r_sel_idx;
    assign scanning   = r_scanning;
    assign winner_idx = r_winner_idx;
    assign tie        = r_tie;

endmodule
`default_nettype wire

// File: tb/tb_vote_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_display_ctrl
// Description : Scoreboard bench for vote_display_ctrl. The stimulus process
//               queues the expected outputs after each clock edge; a monitor
//               pops one entry per falling edge and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        vvc = 1'b0;
    logic [31:0] votes;
    logic [3:0]  btn = 4'b0000;
    logic [7:0]  leds;
    logic [1:0]  sel_idx;
    logic        scanning;
    logic [1:0]  winner_idx;
    logic        tie;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [4:0] c_ALL = 5'b11111;

    typedef struct packed {
        logic [63:0] nm;
        logic [4:0]  m;
        logic [7:0]  leds;
        logic [1:0]  sel;
        logic        scan;
        logic [1:0]  win;
        logic        tie;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    vote_display_ctrl #(
        .NUM_CAND      (4),
        .CNT_W         (8),
        .PULSE_CYCLES  (5),
        .SCROLL_CYCLES (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mode              (mode),
        .valid_vote_casted (vvc),
        .cand_votes        (votes),
        .cand_buttons      (btn),
        .leds              (leds),
        .sel_idx           (sel_idx),
        .scanning          (scanning),
        .winner_idx        (winner_idx),
        .tie               (tie)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic exp_t mk(input logic [63:0] nm, input logic [4:0] m,
                                input logic [7:0] l, input logic [1:0] s,
                                input logic sc, input logic [1:0] w, input logic t);
        exp_t e;
        e.nm = nm; e.m = m; e.leds = l; e.sel = s; e.scan = sc; e.win = w; e.tie = t;
        return e;
    endfunction

    // Advance one edge and queue what the outputs must show after it.
    task automatic ex(input logic [63:0] nm, input logic [4:0] m,
                      input logic [7:0] l, input logic [1:0] s,
                      input logic sc, input logic [1:0] w, input logic t);
        @(posedge clk);
        #1;
        q.push_back(mk(nm, m, l, s, sc, w, t));
    endtask

    task automatic cmp(input logic [63:0] nm, input logic [63:0] f,
                       input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %0s.%0s at %0t: actual=%0h required=%0h", nm, f, $time, act, req);
        end
    endtask

    // Monitor: one expectation consumed per falling edge, away from the active edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            if (mon_e.m[4]) cmp(mon_e.nm, "leds",  leds,                mon_e.leds);
            if (mon_e.m[3]) cmp(mon_e.nm, "sel",   {6'd0, sel_idx},     {6'd0, mon_e.sel});
            if (mon_e.m[2]) cmp(mon_e.nm, "scan",  {7'd0, scanning},    {7'd0, mon_e.scan});
            if (mon_e.m[1]) cmp(mon_e.nm, "win",   {6'd0, winner_idx},  {6'd0, mon_e.win});
            if (mon_e.m[0]) cmp(mon_e.nm, "tie",   {7'd0, tie},         {7'd0, mon_e.tie});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    logic [7:0] sv [4];

    initial begin
        sv[0] = 8'd3; sv[1] = 8'd7; sv[2] = 8'd2; sv[3] = 8'd9;
        votes = pack(8'd3, 8'd7, 8'd2, 8'd9);
        #1 rst = 1'b1;

        // Reset state.
        @(posedge clk); #1;
        q.push_back(mk("rst", c_ALL, 8'h00, 2'd0, 1'b0, 2'd0, 1'b0));
        @(posedge clk); #1 rst = 1'b0;
        ex("idle", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);

        // Acknowledge flash: five cycles of all-ones then dark.
        vvc = 1'b1;
        ex("ack", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b0;
        repeat (4) ex("ack", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        ex("ackend", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);
        ex("idle2", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);

        // Restart: pulse at 10 and 13 -> lit 11..18, dark at 19.
        vvc = 1'b1;
        ex("rs11", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b0;
        ex("rs12", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        ex("rs13", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b1;
        ex("rs14", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b0;
        repeat (4) ex("rs15_18", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        ex("rs19", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);

        // Asynchronous reset in the middle of a flash.
        vvc = 1'b1;
        ex("ack2", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b0;
        ex("ack2", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        @(posedge clk); #1;
        q.push_back(mk("arst", c_ALL, 8'h00, 2'd0, 1'b0, 2'd0, 1'b0));
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ex("postrst", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);

        // Mode 0->1 in the middle of a flash aborts it and starts scanning.
        vvc = 1'b1;
        ex("ack3", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc = 1'b0;
        ex("ack3", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        mode = 1'b1;
        ex("m01ack", c_ALL, 8'd3, 2'd0, 1'b1, 2'd3, 1'b0);

        // Auto-scroll 3,7,2,9,3 for eight cycles each; a vote pulse is ignored.
        for (int k = 1; k <= 40; k++) begin
            vvc = (k == 20);
            ex("scan", c_ALL, sv[(k / 8) % 4], 2'((k / 8) % 4), 1'b1, 2'd3, 1'b0);
        end
        vvc = 1'b0;

        // Two buttons together: lowest index latched and held after release.
        btn = 4'b0110;
        ex("hold", c_ALL, 8'd7, 2'd1, 1'b0, 2'd3, 1'b0);
        btn = 4'b0000;
        repeat (3) ex("held", c_ALL, 8'd7, 2'd1, 1'b0, 2'd3, 1'b0);
        votes = pack(8'd3, 8'd8, 8'd2, 8'd9);
        ex("live", c_ALL, 8'd8, 2'd1, 1'b0, 2'd3, 1'b0);
        btn = 4'b1000;
        ex("relatch", c_ALL, 8'd9, 2'd3, 1'b0, 2'd3, 1'b0);
        btn = 4'b0000;
        ex("relheld", c_ALL, 8'd9, 2'd3, 1'b0, 2'd3, 1'b0);

        // Leader and tie detection.
        votes = pack(8'd5, 8'd9, 8'd9, 8'd1);
        ex("tie", c_ALL, 8'd1, 2'd3, 1'b0, 2'd1, 1'b1);
        votes = pack(8'd5, 8'd9, 8'd10, 8'd1);
        ex("win", c_ALL, 8'd1, 2'd3, 1'b0, 2'd2, 1'b0);
        votes = pack(8'd0, 8'd0, 8'd0, 8'd0);
        ex("zero", c_ALL, 8'd0, 2'd3, 1'b0, 2'd0, 1'b1);
        votes = pack(8'd3, 8'd7, 8'd2, 8'd9);
        ex("restore", c_ALL, 8'd9, 2'd3, 1'b0, 2'd3, 1'b0);

        // Mode 1->0 while holding, then 1->0 with a same-cycle vote.
        mode = 1'b0;
        ex("m10", c_ALL, 8'h00, 2'd0, 1'b0, 2'd3, 1'b0);
        mode = 1'b1;
        ex("m01", c_ALL, 8'd3, 2'd0, 1'b1, 2'd3, 1'b0);
        mode = 1'b0;
        vvc  = 1'b1;
        ex("m10ack", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);
        vvc  = 1'b0;
        ex("m10ack2", c_ALL, 8'hFF, 2'd0, 1'b0, 2'd3, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending entries required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
